sprite_compositor: RTL
======================

Name: sprite_compositor

Overview:
- Parametrised N-channel sprite compositor for the VGA path. Generalises the fixed three-sprite priority mux.
- Sits between the per-sprite engines (index plus drawing flag per channel) and the colour lookup table. Runs on the pixel clock.
- Adds per-channel enable and programmable priority, both double-buffered and swapped at frame start.
- Adds sticky per-channel collision flags and a 2-stage pipeline that keeps sync and blank aligned with the pixel.

Parameters:
- NSPR, 4, number of sprite channels (2..16).
- CIDXW, 4, colour index width (bits).
- PRIW, 2, priority field width; a higher value wins.
- TRANS_INDX, 4'hF, transparent colour index.
- BG_INDX, 4'h0, index output when no opaque channel, or when blanking.
- AW, 4, cfg_addr width; must satisfy 2^AW >= NSPR.

Ports:
- clk  in  1  pixel clock (25 MHz domain).
- reset  in  1  synchronous, active-high reset.
- frame_start  in  1  one-cycle pulse at start of each frame.
- pix_in  in  NSPR*CIDXW  channel i index at [i*CIDXW +: CIDXW].
- drawing_in  in  NSPR  channel i inside its sprite box.
- blank_n_in  in  1  active-video flag from timing.
- hsync_in  in  1  horizontal sync from timing.
- vsync_in  in  1  vertical sync from timing.
- cfg_we  in  1  config write strobe, one word per cycle.
- cfg_addr  in  AW  channel number.
- cfg_wdata  in  1+PRIW  bit0 = enable, [PRIW:1] = priority.
- coll_clr  in  1  clear all collision flags.
- cidx_out  out  CIDXW  composited colour index to the CLUT.
- opaque_out  out  1  an opaque sprite pixel was selected.
- win_id_out  out  4  index of the winning channel (0 when not opaque).
- blank_n_out  out  1  blank_n_in delayed 2 cycles.
- hsync_out  out  1  hsync_in delayed 2 cycles.
- vsync_out  out  1  vsync_in delayed 2 cycles.
- coll_status  out  NSPR  sticky collision flags.

Behaviour:
- Reset, synchronous, highest precedence:
  - pending and active config = 0 (all channels disabled, priority 0).
  - coll_status = 0.
  - Both pipeline stages flushed: cidx_out = BG_INDX, opaque_out = 0, win_id_out = 0, blank_n_out = 0, hsync_out = 1, vsync_out = 1.
  - Reset asserted mid-frame discards in-flight pixels. The first valid output appears 2 cycles after reset deassertion.
- Config, two banks:
  - cfg_we writes the pending bank entry cfg_addr. Writes with cfg_addr >= NSPR are ignored.
  - On frame_start, active <= pending for all channels.
  - A write coinciding with frame_start is included in the copy (write-through to active).
  - Active config never changes other than at frame_start or reset.
- Stage 1 (registered): opq[i] = drawing_in[i] & active_en[i] & (pix_in[i] != TRANS_INDX) & blank_n_in. Also registers pix, blank_n, hsync, vsync.
- Stage 2 (registered), winner selection:
  - The winner is the opq channel with the greatest active priority.
  - Equal priority goes to the lowest channel index.
  - With no winner: cidx_out = BG_INDX, opaque_out = 0, win_id_out = 0.
  - With a winner: cidx_out = winner pix, opaque_out = 1, win_id_out = winner index (zero-extended).
- Latency: exactly 2 clk from inputs to every output, including syncs and blank. No bubbles; one pixel per cycle.
- Collision, evaluated on stage-1 opq:
  - If popcount(opq) >= 2, every channel with opq set gets its coll_status bit set.
  - coll_clr zeroes all bits. A set in the same cycle as coll_clr wins (that bit reads 1 next cycle).
  - Disabled, transparent, or blanked pixels never collide.
- Priority selection must be a balanced compare tree or a loop that synthesises combinationally within stage 2. NSPR up to 16 at 25 MHz.

Test Plan:
- Reset with channels 0,1 drawing and opaque -> outputs hold reset values; coll_status = 0; no winner since channels are disabled.
- Enable ch0 (pri 1) and ch1 (pri 2) via cfg, then pulse frame_start. Both drawing, pix 3 and 5 -> two cycles later cidx_out = 5, win_id_out = 1, coll_status = 4'b0011.
- Equal priority 1 on ch2 and ch3, pix 7 and 9 -> cidx_out = 7, win_id_out = 2.
- Ch0 pix = 4'hF (transparent) over ch1 pix 2 -> cidx_out = 2, no collision. All transparent -> cidx_out = BG_INDX, opaque_out = 0.
- Write ch1 disable mid-frame -> output unaffected until the next frame_start, then ch1 is ignored. A write on the same cycle as frame_start takes effect that frame.
- blank_n_in = 0 with opaque sprites -> BG_INDX and no collision. Apply coll_clr together with a new collision -> the affected bits remain 1.

Source files
------------

// File: rtl/sprite_compositor.sv
// N-channel sprite compositor: double-buffered per-channel enable/priority, a two-stage
// pixel pipeline with sync/blank alignment, and sticky collision flags.
module sprite_compositor #(
    parameter int               NSPR       = 4,
    parameter int               CIDXW      = 4,
    parameter int               PRIW       = 2,
    parameter logic [CIDXW-1:0] TRANS_INDX = 4'hF,
    parameter logic [CIDXW-1:0] BG_INDX    = 4'h0,
    parameter int               AW         = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  frame_start,
    input  logic [NSPR*CIDXW-1:0] pix_in,
    input  logic [NSPR-1:0]       drawing_in,
    input  logic                  blank_n_in,
    input  logic                  hsync_in,
    input  logic                  vsync_in,
    input  logic                  cfg_we,
    input  logic [AW-1:0]         cfg_addr,
    input  logic [PRIW:0]         cfg_wdata,
    input  logic                  coll_clr,
    output logic [CIDXW-1:0]      cidx_out,
    output logic                  opaque_out,
    output logic [3:0]            win_id_out,
    output logic                  blank_n_out,
    output logic                  hsync_out,
    output logic                  vsync_out,
    output logic [NSPR-1:0]       coll_status
);

    logic [NSPR-1:0]      wr_hit;
    logic [NSPR-1:0]      act_en;
    logic [NSPR*PRIW-1:0] act_pri;
    logic [NSPR-1:0]      opq_next;

    logic [NSPR-1:0]       opq_s1_reg;
    logic [NSPR*CIDXW-1:0] pix_s1_reg;
    logic [NSPR*PRIW-1:0]  pri_s1_reg;
    logic                  blank_n_s1_reg;
    logic                  hsync_s1_reg;
    logic                  vsync_s1_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NSPR; gi++) begin : g_chan
            logic            pend_en_reg;
            logic            act_en_reg;
            logic [PRIW-1:0] pend_pri_reg;
            logic [PRIW-1:0] act_pri_reg;

            // Out-of-range addresses match no channel, so those writes simply vanish.
            assign wr_hit[gi] = cfg_we && (cfg_addr == AW'(gi));

            always_ff @(posedge clk) begin
                if (reset) begin
                    pend_en_reg  <= 1'b0;
                    pend_pri_reg <= '0;
                    act_en_reg   <= 1'b0;
                    act_pri_reg  <= '0;
                end else begin
                    if (wr_hit[gi]) begin
                        pend_en_reg  <= cfg_wdata[0];
                        pend_pri_reg <= cfg_wdata[PRIW:1];
                    end
                    // A write landing on frame_start goes straight through to the active bank.
                    if (frame_start) begin
                        act_en_reg  <= wr_hit[gi] ? cfg_wdata[0]      : pend_en_reg;
                        act_pri_reg <= wr_hit[gi] ? cfg_wdata[PRIW:1] : pend_pri_reg;
                    end
                end
            end

            assign act_en[gi]                  = act_en_reg;
            assign act_pri[gi*PRIW +: PRIW]    = act_pri_reg;
            assign opq_next[gi] = drawing_in[gi] & act_en_reg & blank_n_in &
                                  (pix_in[gi*CIDXW +: CIDXW] != TRANS_INDX);
        end
    endgenerate

    // Stage 1: opacity per channel; priorities travel with the pixel so a frame-start
    // swap cannot split one pixel across two configurations.
    always_ff @(posedge clk) begin
        if (reset) begin
            opq_s1_reg     <= '0;
            pix_s1_reg     <= '0;
            pri_s1_reg     <= '0;
            blank_n_s1_reg <= 1'b0;
            hsync_s1_reg   <= 1'b1;
            vsync_s1_reg   <= 1'b1;
        end else begin
            opq_s1_reg     <= opq_next;
            pix_s1_reg     <= pix_in;
            pri_s1_reg     <= act_pri;
            blank_n_s1_reg <= blank_n_in;
            hsync_s1_reg   <= hsync_in;
            vsync_s1_reg   <= vsync_in;
        end
    end

    logic             win_found;
    logic [PRIW-1:0]  win_pri;
    logic [3:0]       win_id;
    logic [CIDXW-1:0] win_pix;

    // Strict greater-than keeps the lowest-index channel on a priority tie.
    always_comb begin
        win_found = 1'b0;
        win_pri   = '0;
        win_id    = 4'd0;
        win_pix   = BG_INDX;
        for (int i = 0; i < NSPR; i++) begin
            if (opq_s1_reg[i] && (!win_found || (pri_s1_reg[i*PRIW +: PRIW] > win_pri))) begin
                win_found = 1'b1;
                win_pri   = pri_s1_reg[i*PRIW +: PRIW];
                win_id    = 4'(i);
                win_pix   = pix_s1_reg[i*CIDXW +: CIDXW];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cidx_out    <= BG_INDX;
            opaque_out  <= 1'b0;
            win_id_out  <= 4'd0;
            blank_n_out <= 1'b0;
            hsync_out   <= 1'b1;
            vsync_out   <= 1'b1;
        end else begin
            cidx_out    <= win_pix;
            opaque_out  <= win_found;
            win_id_out  <= win_id;
            blank_n_out <= blank_n_s1_reg;
            hsync_out   <= hsync_s1_reg;
            vsync_out   <= vsync_s1_reg;
        end
    end

    // Two or more bits set iff clearing the lowest set bit leaves something behind.
    logic            multi_opq;
    logic [NSPR-1:0] coll_set;
    assign multi_opq = |(opq_s1_reg & (opq_s1_reg - NSPR'(1)));
    assign coll_set  = multi_opq ? opq_s1_reg : '0;

    always_ff @(posedge clk) begin
        if (reset)
            coll_status <= '0;
        else if (coll_clr)
            coll_status <= coll_set;
        else
            coll_status <= coll_status | coll_set;
    end

endmodule
